uart_byte_rx: RTL and testbench

//  - Modbus RTU serial byte receiver. Converts the RS-485 RX line into bytes.
//  - Drives rx_done, rx_state and rx_data into the inter-character (1T) gap checker and the frame assembler.
//  - 8 data bits, LSB first, 1 stop bit. Even/odd parity is optional.

---
 rtl/uart_byte_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_byte_rx : Modbus RTU 8-bit serial receiver, LSB first, one stop bit.
//   Define UART_RX_PARITY_EN for the 11-bit even/odd parity character.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_byte_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rs485_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       rx_err,
  output logic       rx_par_err
);

  localparam int          c_bps     = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] c_bps_m1  = 16'(c_bps - 1);
  localparam logic [15:0] c_hbps_m1 = 16'((c_bps / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, hist_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  assign w_par_bad = par_q ^ (^shift_q) ^ PARITY_ODD;
`else
  assign w_par_bad = 1'b0;
`endif

  // Synchronizers idle high so leaving reset never fakes a start edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rs485_rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q && hist_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == c_hbps_m1) begin
          cnt_d   = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == c_bps_m1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (cnt_q == c_bps_m1) begin
          cnt_d   = '0;
          par_d   = sync2_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == c_bps_m1) begin
          cnt_d = '0;
          if (!sync2_q) begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            done_d  = 1'b1;
            data_d  = shift_q;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Busy only in the character states, so it is already low when a pulse fires.
  assign rx_state = (state_q == S_START) || (state_q == S_DATA) ||
`ifdef UART_RX_PARITY_EN
                    (state_q == S_PAR) ||
`endif
                    (state_q == S_STOP);
  assign rx_data  = data_q;
  assign rx_done  = done_q;
  assign rx_err   = err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_par_err = perr_q;
`else
  // PARITY_ODD has no effect in this build.
  assign rx_par_err = PARITY_ODD & 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_byte_rx : scoreboard bench for uart_byte_rx at BPS=10, HBPS=5.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_byte_rx;

  localparam int c_bps = 10;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;
  localparam int K_PERR = 3;
`ifdef UART_RX_PARITY_EN
  localparam int c_lat = 108;
`else
  localparam int c_lat = 98;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rs485_rx;
  logic [7:0] rx_data;
  logic       rx_done, rx_state, rx_err, rx_par_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t q[$];

  uart_byte_rx #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rs485_rx  (rs485_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_state  (rx_state),
    .rx_err    (rx_err),
    .rx_par_err(rx_par_err)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rs485_rx = b;
    repeat (n) @(negedge clk_in);
  endtask

  // Called on a negedge; E lands two cycles later, the pulse at E+96 (E+106).
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b, input int kind);
    exp_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.data = d;
      e.at   = cyc + c_lat;
      q.push_back(e);
    end
    drive(1'b0, c_bps);
    for (int i = 0; i < 8; i++) drive(d[i], c_bps);
`ifdef UART_RX_PARITY_EN
    drive(par_b, c_bps);
`endif
    drive(stop_b, c_bps);
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, 1'b1, ^d, K_DONE);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},    int'(rx_data),    0);
    chk({tag, "_done"},    int'(rx_done),    0);
    chk({tag, "_state"},   int'(rx_state),   0);
    chk({tag, "_err"},     int'(rx_err),     0);
    chk({tag, "_par_err"}, int'(rx_par_err), 0);
  endtask

  // Monitor: every pulse is matched against the head of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst_in && (rx_done || rx_err || rx_par_err)) begin
      int k;
      exp_t e;
      k = rx_done ? K_DONE : (rx_err ? K_ERR : K_PERR);
      chk("one_hot_pulse", int'(rx_done) + int'(rx_err) + int'(rx_par_err), 1);
      if (rx_done) chk("state_low_on_done", int'(rx_state), 0);
      if (q.size() == 0) begin
        chk("spurious_pulse_kind", k, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.at);
        if (e.kind == K_DONE) chk("rx_data", int'(rx_data), int'(e.data));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    rst_in   = 1'b1;
    rs485_rx = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst_in = 1'b0;
    drive(1'b1, 20 * c_bps);

    // 1: single good byte
    good(8'hA5);
    drive(1'b1, 5 * c_bps);

    // 2: 3-cycle glitch is a false start
    k0 = cyc;
    drive(1'b0, 3);
    rs485_rx = 1'b1;
    for (int i = 3; i <= 8; i++) begin
      while (cyc < k0 + i) @(negedge clk_in);
      chk($sformatf("false_start_state_E+%0d", i - 2), int'(rx_state), (i <= 7) ? 1 : 0);
    end
    drive(1'b1, 5 * c_bps);

    // 3: framing error, held break, then recovery
    send_frame(8'h00, 1'b0, 1'b0, K_ERR);
    drive(1'b0, 30 * c_bps);
    drive(1'b1, 5 * c_bps);
    good(8'h3C);
    drive(1'b1, 5 * c_bps);

    // 4: back-to-back bytes
    good(8'h01);
    good(8'h03);
    drive(1'b1, 5 * c_bps);

    // 5: reset during bit 4 of 0xFF
    drive(1'b0, c_bps);
    drive(1'b1, 4 * c_bps + 3);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    chk_all_zero("midbyte_reset");
    drive(1'b1, 7 + 3 * c_bps);
`ifdef UART_RX_PARITY_EN
    drive(1'b1, c_bps);
`endif
    drive(1'b1, 10 * c_bps);
    good(8'h5A);
    drive(1'b1, 5 * c_bps);

`ifdef UART_RX_PARITY_EN
    // 6: parity good, then parity bad
    send_frame(8'h07, 1'b1, 1'b1, K_DONE);
    drive(1'b1, 5 * c_bps);
    send_frame(8'h07, 1'b1, 1'b0, K_PERR);
    drive(1'b1, 5 * c_bps);
    chk("data_held_after_par_err", int'(rx_data), 8'h07);
`endif

    drive(1'b1, 30 * c_bps);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
